// File: rtl/trace_packer.sv
// trace_packer: packs 2**NTRACE-bit trace samples into WIDTH-bit memory words.
// Words are delivered through a valid/ready store handshake.
//
// Capture adds sample decimation and a configurable trigger (edge or level, either polarity).
// After the trigger, a delay counter captures a set number of further samples, then any
// partial word is flushed. A sticky flag records completed words dropped under backpressure.
//
// Ports:
//   FPGA_CLK_I    sole clock
//   RST_I         asynchronous active-high reset
//   EN_I          capture enable; low freezes sampling and counters
//   ARM_I         one-cycle pulse; latches configuration and (re)starts capture
//   NTRACE_I      log2 of traces per sample (latched on ARM_I)
//   TRIG_MODE_I   bit1: 0=edge 1=level; bit0: 0=rising/high 1=falling/low (latched on ARM_I)
//   DELAY_I       samples captured after trigger before flush (latched on ARM_I)
//   DECIM_I       sample every DECIM_I+1 enabled cycles (latched on ARM_I)
//   FPGA_TRIG_I   trigger input
//   FPGA_TRACE_I  trace input; only the low 2**NTRACE bits are used
//   DATA_O        word to memory
//   VALID_O       DATA_O valid
//   READY_I       memory accepts word
//   EVENT_POS_O   bit position of the trigger within its word
//   TRIG_SEEN_O   sticky: trigger detected
//   TRG_EVENT_O   sticky: delay expired
//   DONE_O        capture finished, last word accepted
//   OVERFLOW_O    sticky: completed word dropped
//   FPGA_TRIG_O   copy of TRG_EVENT_O for daisy-chaining
module trace_packer #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MAX_TRACES  = 8,
    parameter int unsigned NTRACE_BITS = $clog2($clog2(MAX_TRACES) + 1),
    parameter int unsigned DELAY_BITS  = 16,
    parameter int unsigned DECIM_BITS  = 8
) (
    input  logic                     FPGA_CLK_I,
    input  logic                     RST_I,
    input  logic                     EN_I,
    input  logic                     ARM_I,
    input  logic [NTRACE_BITS-1:0]   NTRACE_I,
    input  logic [1:0]               TRIG_MODE_I,
    input  logic [DELAY_BITS-1:0]    DELAY_I,
    input  logic [DECIM_BITS-1:0]    DECIM_I,
    input  logic                     FPGA_TRIG_I,
    input  logic [MAX_TRACES-1:0]    FPGA_TRACE_I,
    output logic [WIDTH-1:0]         DATA_O,
    output logic                     VALID_O,
    input  logic                     READY_I,
    output logic [$clog2(WIDTH)-1:0] EVENT_POS_O,
    output logic                     TRIG_SEEN_O,
    output logic                     TRG_EVENT_O,
    output logic                     DONE_O,
    output logic                     OVERFLOW_O,
    output logic                     FPGA_TRIG_O
);

    localparam int unsigned PosBits   = $clog2(WIDTH);
    localparam int unsigned MaxNtrace = $clog2(MAX_TRACES);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StDelay,
        StFlush,
        StWait,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [NTRACE_BITS-1:0] ntrace_q, ntrace_d;
    logic [1:0]             trig_mode_q, trig_mode_d;
    logic [DELAY_BITS-1:0]  delay_q, delay_d;
    logic [DECIM_BITS-1:0]  decim_q, decim_d;
    logic [PosBits-1:0]     pos_q, pos_d;
    logic [DECIM_BITS-1:0]  decim_cnt_q, decim_cnt_d;
    logic [DELAY_BITS-1:0]  delay_cnt_q, delay_cnt_d;
    logic [WIDTH-1:0]       trace_q, trace_d;
    logic                   trig_prev_q, trig_prev_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   valid_q, valid_d;
    logic [PosBits-1:0]     event_pos_q, event_pos_d;
    logic                   trig_seen_q, trig_seen_d;
    logic                   trg_event_q, trg_event_d;
    logic                   overflow_q, overflow_d;

    logic [PosBits:0]       num;
    logic [MAX_TRACES-1:0]  sample_mask;
    logic [WIDTH-1:0]       field_mask;
    logic [WIDTH-1:0]       sample_w;
    logic [WIDTH-1:0]       trace_ins;
    logic                   word_last;
    logic                   load_ok;
    logic                   capturing;
    logic                   strobe;
    logic                   trig_hit;

    // Datapath helpers derived from the latched configuration
    always_comb begin
        num = (PosBits + 1)'(1) << ntrace_q;
        for (int i = 0; i < MAX_TRACES; i++) begin
            sample_mask[i] = ((PosBits + 1)'(i) < num);
        end
        field_mask = WIDTH'(sample_mask);
        sample_w   = WIDTH'(FPGA_TRACE_I & sample_mask);
        // Clear the target field before inserting so stale bits can never leak in
        trace_ins  = (trace_q & ~(field_mask << pos_q)) | (sample_w << pos_q);
        word_last  = (({1'b0, pos_q} + num) == (PosBits + 1)'(WIDTH));
        load_ok    = !valid_q || READY_I;
        capturing  = (state_q == StArmed) || (state_q == StDelay);
        strobe     = EN_I && capturing && (decim_cnt_q == '0);
        // Edge modes additionally require a change since the previous cycle
        trig_hit   = (trig_mode_q[1] || (FPGA_TRIG_I != trig_prev_q)) &&
                     (FPGA_TRIG_I == !trig_mode_q[0]);
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        ntrace_d    = ntrace_q;
        trig_mode_d = trig_mode_q;
        delay_d     = delay_q;
        decim_d     = decim_q;
        pos_d       = pos_q;
        decim_cnt_d = decim_cnt_q;
        delay_cnt_d = delay_cnt_q;
        trace_d     = trace_q;
        trig_prev_d = FPGA_TRIG_I;
        data_d      = data_q;
        valid_d     = valid_q;
        event_pos_d = event_pos_q;
        trig_seen_d = trig_seen_q;
        trg_event_d = trg_event_q;
        overflow_d  = overflow_q;

        // Handshake retires the current word; a new load below overrides this
        if (valid_q && READY_I) begin
            valid_d = 1'b0;
        end

        if (ARM_I) begin
            // Out-of-range sample widths saturate to the widest supported sample
            if (NTRACE_I > NTRACE_BITS'(MaxNtrace)) begin
                ntrace_d = NTRACE_BITS'(MaxNtrace);
            end else begin
                ntrace_d = NTRACE_I;
            end
            trig_mode_d = TRIG_MODE_I;
            delay_d     = DELAY_I;
            decim_d     = DECIM_I;
            pos_d       = '0;
            decim_cnt_d = '0;
            delay_cnt_d = '0;
            trace_d     = '0;
            event_pos_d = '0;
            trig_seen_d = 1'b0;
            trg_event_d = 1'b0;
            overflow_d  = 1'b0;
            state_d     = StArmed;
        end else begin
            if (EN_I && capturing) begin
                decim_cnt_d = (decim_cnt_q == decim_q) ? '0 : decim_cnt_q + 1'b1;
            end

            if (strobe) begin
                if (word_last) begin
                    pos_d   = '0;
                    trace_d = '0;
                    if (load_ok) begin
                        data_d  = trace_ins;
                        valid_d = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    pos_d   = pos_q + num[PosBits-1:0];
                    trace_d = trace_ins;
                end
            end

            unique case (state_q)
                StIdle: begin
                end
                StArmed: begin
                    if (trig_hit) begin
                        event_pos_d = pos_q;
                        trig_seen_d = 1'b1;
                        if (delay_q == '0) begin
                            state_d = StFlush;
                        end else begin
                            state_d     = StDelay;
                            delay_cnt_d = delay_q;
                        end
                    end
                end
                StDelay: begin
                    if (strobe) begin
                        delay_cnt_d = delay_cnt_q - 1'b1;
                        if (delay_cnt_q == DELAY_BITS'(1)) begin
                            state_d = StFlush;
                        end
                    end
                end
                StFlush: begin
                    // The partial word is never dropped: hold here until it can load
                    if (pos_q != '0) begin
                        if (load_ok) begin
                            data_d  = trace_q;
                            valid_d = 1'b1;
                            pos_d   = '0;
                            trace_d = '0;
                            state_d = StWait;
                        end
                    end else begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (!valid_q) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            if ((state_d == StFlush) && (state_q != StFlush)) begin
                trg_event_d = 1'b1;
            end
        end
    end

    always_ff @(posedge FPGA_CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q     <= StIdle;
            ntrace_q    <= '0;
            trig_mode_q <= '0;
            delay_q     <= '0;
            decim_q     <= '0;
            pos_q       <= '0;
            decim_cnt_q <= '0;
            delay_cnt_q <= '0;
            trace_q     <= '0;
            trig_prev_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            event_pos_q <= '0;
            trig_seen_q <= 1'b0;
            trg_event_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ntrace_q    <= ntrace_d;
            trig_mode_q <= trig_mode_d;
            delay_q     <= delay_d;
            decim_q     <= decim_d;
            pos_q       <= pos_d;
            decim_cnt_q <= decim_cnt_d;
            delay_cnt_q <= delay_cnt_d;
            trace_q     <= trace_d;
            trig_prev_q <= trig_prev_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            event_pos_q <= event_pos_d;
            trig_seen_q <= trig_seen_d;
            trg_event_q <= trg_event_d;
            overflow_q  <= overflow_d;
        end
    end

    assign DATA_O      = data_q;
    assign VALID_O     = valid_q;
    assign EVENT_POS_O = event_pos_q;
    assign TRIG_SEEN_O = trig_seen_q;
    assign TRG_EVENT_O = trg_event_q;
    assign DONE_O      = (state_q == StDone);
    assign OVERFLOW_O  = overflow_q;
    assign FPGA_TRIG_O = trg_event_q;

endmodule

// File: tb/tb_trace_packer.sv
// Directed testbench for trace_packer (default parameters).
module tb_trace_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        arm_p = 1'b0;
    logic [1:0]  ntrace = '0;
    logic [1:0]  trig_mode = '0;
    logic [15:0] delay = '0;
    logic [7:0]  decim = '0;
    logic        trig = 1'b0;
    logic [7:0]  trace = '0;
    logic [31:0] data;
    logic        valid;
    logic        ready = 1'b1;
    logic [4:0]  event_pos;
    logic        trig_seen;
    logic        trg_event;
    logic        done;
    logic        overflow;
    logic        trig_out;

    int errors = 0;
    int checks = 0;

    trace_packer dut (
        .FPGA_CLK_I   (clk),
        .RST_I        (rst),
        .EN_I         (en),
        .ARM_I        (arm_p),
        .NTRACE_I     (ntrace),
        .TRIG_MODE_I  (trig_mode),
        .DELAY_I      (delay),
        .DECIM_I      (decim),
        .FPGA_TRIG_I  (trig),
        .FPGA_TRACE_I (trace),
        .DATA_O       (data),
        .VALID_O      (valid),
        .READY_I      (ready),
        .EVENT_POS_O  (event_pos),
        .TRIG_SEEN_O  (trig_seen),
        .TRG_EVENT_O  (trg_event),
        .DONE_O       (done),
        .OVERFLOW_O   (overflow),
        .FPGA_TRIG_O  (trig_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic arm(input logic [1:0] nt, input logic [1:0] mode, input logic [15:0] dly,
                       input logic [7:0] dec);
        ntrace    = nt;
        trig_mode = mode;
        delay     = dly;
        decim     = dec;
        arm_p     = 1'b1;
        tick();
        arm_p     = 1'b0;
        ntrace    = '0;
        trig_mode = '0;
        delay     = '0;
        decim     = '0;
    endtask

    logic [7:0] t3_bits;

    initial begin
        // Reset
        #1 rst = 1'b1;
        #2;
        chk("rst_data", data, 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_flags", {27'h0, trig_seen, trg_event, done, overflow, trig_out}, 32'h0);
        chk("rst_event_pos", 32'(event_pos), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Test 1: 2-bit samples k=0..15 pack to 0xE4E4E4E4
        en = 1'b1;
        ready = 1'b1;
        trig = 1'b0;
        arm(2'd1, 2'b00, 16'd4, 8'd0);
        for (int k = 0; k < 15; k++) begin
            trace = 8'(k);
            tick();
        end
        chk("t1_valid_before", 32'(valid), 32'h0);
        trace = 8'd15;
        tick();
        chk("t1_valid", 32'(valid), 32'h1);
        chk("t1_data", data, 32'hE4E4E4E4);
        tick();
        chk("t1_valid_one_cycle", 32'(valid), 32'h0);

        // Test 2: 8-bit samples, rising edge in the 6th sample cycle, DELAY=2
        arm(2'd3, 2'b00, 16'd2, 8'd0);
        for (int n = 1; n <= 4; n++) begin
            trace = 8'(8'h10 + n);
            tick();
        end
        chk("t2_word1_valid", 32'(valid), 32'h1);
        chk("t2_word1_data", data, 32'h14131211);
        trace = 8'h15;
        tick();
        chk("t2_word1_taken", 32'(valid), 32'h0);
        trace = 8'h16;
        trig = 1'b1;
        tick();
        chk("t2_event_pos", 32'(event_pos), 32'd8);
        chk("t2_trig_seen", 32'(trig_seen), 32'h1);
        chk("t2_trg_event_early", 32'(trg_event), 32'h0);
        trace = 8'h17;
        tick();
        trace = 8'h18;
        tick();
        chk("t2_word2_valid", 32'(valid), 32'h1);
        chk("t2_word2_data", data, 32'h18171615);
        chk("t2_trg_event", 32'(trg_event), 32'h1);
        chk("t2_trig_out", 32'(trig_out), 32'h1);
        tick();
        chk("t2_done_early", 32'(done), 32'h0);
        tick();
        chk("t2_done", 32'(done), 32'h1);

        // Test 3: 1-bit samples, low-level trigger, DELAY=3, partial flush word 0x16D
        trig = 1'b1;
        arm(2'd0, 2'b11, 16'd3, 8'd0);
        chk("t3_done_cleared", 32'(done), 32'h0);
        chk("t3_trg_event_cleared", 32'(trg_event), 32'h0);
        t3_bits = 8'b0110_1101;
        for (int n = 0; n < 8; n++) begin
            trace = {7'b1010101, t3_bits[n]};
            if (n == 5) trig = 1'b0;
            tick();
            if (n == 5) chk("t3_event_pos", 32'(event_pos), 32'd5);
        end
        trace = 8'hFF;
        tick();
        chk("t3_in_flush", 32'(trg_event), 32'h1);
        chk("t3_no_word_yet", 32'(valid), 32'h0);
        tick();
        chk("t3_flush_valid", 32'(valid), 32'h1);
        chk("t3_flush_data", data, 32'h0000016D);
        tick();
        chk("t3_taken", 32'(valid), 32'h0);
        chk("t3_done_early", 32'(done), 32'h0);
        tick();
        chk("t3_done", 32'(done), 32'h1);

        // Test 4: backpressure, second word dropped
        trig = 1'b0;
        ready = 1'b0;
        arm(2'd3, 2'b00, 16'd1, 8'd0);
        for (int n = 1; n <= 8; n++) begin
            trace = 8'(8'hA0 + n);
            tick();
            if (n == 4) chk("t4_word1_data", data, 32'hA4A3A2A1);
        end
        chk("t4_held_valid", 32'(valid), 32'h1);
        chk("t4_held_data", data, 32'hA4A3A2A1);
        chk("t4_overflow", 32'(overflow), 32'h1);
        en = 1'b0;
        ready = 1'b1;
        tick();
        chk("t4_transferred", 32'(valid), 32'h0);
        chk("t4_overflow_sticky", 32'(overflow), 32'h1);

        // Test 5: DECIM=3 with EN_I off every third cycle
        en = 1'b1;
        arm(2'd3, 2'b00, 16'd1, 8'd3);
        chk("t5_overflow_cleared", 32'(overflow), 32'h0);
        for (int i = 0; i < 18; i++) begin
            en = ((i % 3) != 2);
            trace = 8'(i);
            tick();
        end
        chk("t5_not_yet", 32'(valid), 32'h0);
        en = 1'b1;
        trace = 8'd18;
        tick();
        chk("t5_valid", 32'(valid), 32'h1);
        chk("t5_data", data, 32'h120C0600);

        // Test 6: asynchronous reset in the middle of DELAY
        arm(2'd0, 2'b00, 16'd5, 8'd0);
        trace = 8'h01;
        tick();
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        chk("t6_event_pos", 32'(event_pos), 32'd2);
        chk("t6_trig_seen", 32'(trig_seen), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_data", data, 32'h0);
        chk("t6_rst_outputs", {25'h0, event_pos, valid, trig_seen}, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            trig = i[0];
            tick();
        end
        chk("t6_idle_flags", {27'h0, trig_seen, trg_event, done, overflow, trig_out}, 32'h0);
        chk("t6_idle_valid", 32'(valid), 32'h0);

        // Test 7: high-level trigger with DELAY=0 flushes the trigger-cycle sample
        trig = 1'b0;
        arm(2'd3, 2'b10, 16'd0, 8'd0);
        trig = 1'b1;
        trace = 8'h5A;
        tick();
        chk("t7_event_pos", 32'(event_pos), 32'd0);
        chk("t7_trig_out", 32'(trig_out), 32'h1);
        trace = 8'hC3;
        tick();
        chk("t7_flush_valid", 32'(valid), 32'h1);
        chk("t7_flush_data", data, 32'h0000005A);
        tick();
        tick();
        chk("t7_done", 32'(done), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
